// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encoding and IF/ID record for the fetch stage.
package fetch_unit_pkg;
    localparam int              WORD_W   = 16;
    localparam logic [4:0]      OP_HALT  = 5'b00000;
    localparam logic [4:0]      OP_NOP   = 5'b00001;
    localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;
    localparam logic [WORD_W-1:0] NOP_WORD = {OP_NOP, 11'b0};

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_next;
    } ifid_t;

    function automatic logic is_halt(input logic [4:0] op);
        return op == OP_HALT;
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage handshake: decode side, redirect path and instruction memory port.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              stall;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_rdy;
    logic [WORD_W-1:0] imem_data;
    logic              if_valid;
    logic [WORD_W-1:0] if_instr;
    logic [WORD_W-1:0] if_pc_next;
    logic              halted;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdy, imem_data,
        output imem_req, imem_addr, if_valid, if_instr, if_pc_next, halted
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdy, imem_data,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc_next, halted
    );
endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter: async-reset register with load enable.
module pc_register #(
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_q <= RST_VAL;
        else if (i_load) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, IF/ID register, one-entry skid buffer and FETCH/HOLD/HALT FSM.
module fetch_unit import fetch_unit_pkg::*; (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  io_bus
);
    fetch_state_e      r_state;
    ifid_t             r_ifid;
    ifid_t             r_skid;
    logic              r_if_valid;
    logic              r_skid_vld;

    logic [WORD_W-1:0] w_pc;
    logic [WORD_W-1:0] w_pc_plus2;
    logic [WORD_W-1:0] w_pc_d;
    logic              w_take;
    logic              w_ifid_free;

    assign w_pc_plus2  = w_pc + 16'd2;
    assign w_take      = (r_state == ST_FETCH) && io_bus.imem_rdy;
    assign w_ifid_free = !r_if_valid || !io_bus.stall;
    // PC advances only when a word actually returns; redirect overrides it
    assign w_pc_d      = io_bus.redirect ? (io_bus.redirect_pc & ~16'h0001) : w_pc_plus2;

    pc_register #(.W(WORD_W), .RST_VAL(RESET_PC)) u_pc (
        .clk    (clk),
        .rst    (rst),
        .i_load (io_bus.redirect || w_take),
        .i_d    (w_pc_d),
        .o_q    (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_ifid     <= '{instr: NOP_WORD, pc_next: RESET_PC};
            r_skid     <= '0;
            r_if_valid <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (io_bus.redirect) begin
            r_state    <= ST_FETCH;
            r_if_valid <= 1'b0;
            r_skid_vld <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (io_bus.imem_rdy) begin
                        if (w_ifid_free) begin
                            r_ifid     <= '{instr: io_bus.imem_data, pc_next: w_pc_plus2};
                            r_if_valid <= 1'b1;
                            if (is_halt(io_bus.imem_data[15:11])) r_state <= ST_HALT;
                        end else begin
                            // decode is stalled on a full IF/ID: park the word
                            r_skid     <= '{instr: io_bus.imem_data, pc_next: w_pc_plus2};
                            r_skid_vld <= 1'b1;
                            r_state    <= ST_HOLD;
                        end
                    end else if (!io_bus.stall) begin
                        r_if_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!io_bus.stall && r_skid_vld) begin
                        r_ifid     <= r_skid;
                        r_if_valid <= 1'b1;
                        r_skid_vld <= 1'b0;
                        r_state    <= is_halt(r_skid.instr[15:11]) ? ST_HALT : ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (!io_bus.stall) r_if_valid <= 1'b0;
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign io_bus.imem_req   = (r_state == ST_FETCH);
    assign io_bus.imem_addr  = w_pc;
    assign io_bus.if_valid   = r_if_valid;
    assign io_bus.if_instr   = r_ifid.instr;
    assign io_bus.if_pc_next = r_ifid.pc_next;
    assign io_bus.halted     = (r_state == ST_HALT);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table, async-reset check and randomized order/address scoreboard for fetch_unit.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    logic hmem;
    int   n_chk  = 0;
    int   n_fail = 0;

    fetch_unit_if bus();

    fetch_unit u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Program image: addr 0 holds a NOP, addr 2 optionally a HALT, everything else a non-HALT word.
    function automatic logic [15:0] mem_word(input logic [15:0] a, input logic hm);
        if (a == 16'h0000) return 16'h0800;
        if (hm && a == 16'h0002) return 16'h0000;
        return {2'b11, a[13:0]};
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr, hmem);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".req"},    {15'b0, bus.imem_req}, 16'd1);
        chk({tag, ".addr"},   bus.imem_addr,         16'h0000);
        chk({tag, ".vld"},    {15'b0, bus.if_valid}, 16'd0);
        chk({tag, ".instr"},  bus.if_instr,          16'h0800);
        chk({tag, ".pcn"},    bus.if_pc_next,        16'h0000);
        chk({tag, ".halted"}, {15'b0, bus.halted},   16'd0);
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        rdy;
        logic        hm;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic        chk_ifid;
        logic [15:0] instr;
        logic [15:0] pcn;
        logic        halted;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [15:0] exp_fetch;
        logic [15:0] exp_cons;
        logic        synced;
        int          n_cons;

        // stall redir rpc rdy hm | req addr vld chk instr pcn halted
        tbl.push_back('{0,0,16'h0000,1,0, 1,16'h0002,1,1,16'h0800,16'h0002,0});
        tbl.push_back('{0,0,16'h0000,1,0, 1,16'h0004,1,1,16'hC002,16'h0004,0});
        tbl.push_back('{1,0,16'h0000,1,0, 0,16'h0006,1,1,16'hC002,16'h0004,0});
        tbl.push_back('{1,0,16'h0000,1,0, 0,16'h0006,1,1,16'hC002,16'h0004,0});
        tbl.push_back('{1,0,16'h0000,1,0, 0,16'h0006,1,1,16'hC002,16'h0004,0});
        tbl.push_back('{0,0,16'h0000,1,0, 1,16'h0006,1,1,16'hC004,16'h0006,0});
        tbl.push_back('{0,0,16'h0000,1,0, 1,16'h0008,1,1,16'hC006,16'h0008,0});
        tbl.push_back('{1,1,16'h0103,1,0, 1,16'h0102,0,0,16'h0000,16'h0000,0});
        tbl.push_back('{0,0,16'h0000,0,0, 1,16'h0102,0,0,16'h0000,16'h0000,0});
        tbl.push_back('{0,0,16'h0000,1,0, 1,16'h0104,1,1,16'hC102,16'h0104,0});
        tbl.push_back('{0,0,16'h0000,0,0, 1,16'h0104,0,0,16'h0000,16'h0000,0});
        tbl.push_back('{0,1,16'hFFFE,0,0, 1,16'hFFFE,0,0,16'h0000,16'h0000,0});
        tbl.push_back('{0,0,16'h0000,1,0, 1,16'h0000,1,1,16'hFFFE,16'h0000,0});
        tbl.push_back('{1,0,16'h0000,0,0, 1,16'h0000,1,1,16'hFFFE,16'h0000,0});
        tbl.push_back('{0,0,16'h0000,1,1, 1,16'h0002,1,1,16'h0800,16'h0002,0});
        tbl.push_back('{0,0,16'h0000,1,1, 0,16'h0004,1,1,16'h0000,16'h0004,1});
        tbl.push_back('{1,0,16'h0000,1,1, 0,16'h0004,1,1,16'h0000,16'h0004,1});
        tbl.push_back('{0,0,16'h0000,1,1, 0,16'h0004,0,0,16'h0000,16'h0000,1});
        tbl.push_back('{0,0,16'h0000,1,1, 0,16'h0004,0,0,16'h0000,16'h0000,1});
        tbl.push_back('{0,1,16'h0020,1,1, 1,16'h0020,0,0,16'h0000,16'h0000,0});
        tbl.push_back('{0,0,16'h0000,1,0, 1,16'h0022,1,1,16'hC020,16'h0022,0});

        rst = 1'b1;
        hmem = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.imem_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state("rst_held");
        rst = 1'b0;
        #1;
        chk_reset_state("rst_release");

        foreach (tbl[i]) begin
            bus.stall       = tbl[i].stall;
            bus.redirect    = tbl[i].redir;
            bus.redirect_pc = tbl[i].rpc;
            bus.imem_rdy    = tbl[i].rdy;
            hmem            = tbl[i].hm;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("row%0d.req", i),    {15'b0, bus.imem_req}, {15'b0, tbl[i].req});
            chk($sformatf("row%0d.addr", i),   bus.imem_addr,         tbl[i].addr);
            chk($sformatf("row%0d.vld", i),    {15'b0, bus.if_valid}, {15'b0, tbl[i].vld});
            chk($sformatf("row%0d.halted", i), {15'b0, bus.halted},   {15'b0, tbl[i].halted});
            if (tbl[i].chk_ifid) begin
                chk($sformatf("row%0d.instr", i), bus.if_instr,   tbl[i].instr);
                chk($sformatf("row%0d.pcn", i),   bus.if_pc_next, tbl[i].pcn);
            end
        end

        // Park a word in the skid buffer, then hit reset between clock edges.
        bus.redirect = 1'b0;
        bus.stall    = 1'b1;
        bus.imem_rdy = 1'b1;
        hmem         = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hold.req", {15'b0, bus.imem_req}, 16'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst.instr", bus.if_instr,   16'h0800);
        chk("post_rst.pcn",   bus.if_pc_next, 16'h0002);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst2.instr", bus.if_instr, 16'hC002);
        chk("post_rst2.addr",  bus.imem_addr, 16'h0004);

        // Random traffic: every consumed word must be the next one in program order.
        synced = 1'b0;
        n_cons = 0;
        exp_fetch = 16'h0000;
        exp_cons  = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            bus.stall       = ($urandom_range(0, 9) < 4);
            bus.imem_rdy    = ($urandom_range(0, 9) < 6);
            bus.redirect    = (c == 0) || ($urandom_range(0, 99) < 3);
            bus.redirect_pc = 16'($urandom);
            #1;
            if (synced) begin
                if (bus.imem_req) chk("rnd.addr", bus.imem_addr, exp_fetch);
                if (bus.if_valid && !bus.stall && !bus.redirect) begin
                    chk("rnd.instr", bus.if_instr,   mem_word(exp_cons, 1'b0));
                    chk("rnd.pcn",   bus.if_pc_next, exp_cons + 16'd2);
                    exp_cons = exp_cons + 16'd2;
                    n_cons++;
                end
            end
            if (bus.redirect) begin
                exp_fetch = bus.redirect_pc & 16'hFFFE;
                exp_cons  = exp_fetch;
                synced    = 1'b1;
            end else if (bus.imem_req && bus.imem_rdy) begin
                exp_fetch = exp_fetch + 16'd2;
            end
            n_chk++;
            if (16'(exp_fetch - exp_cons) > 16'd4) begin
                n_fail++;
                $display("FAIL rnd.inflight: got %0d bytes outstanding, expected at most 4",
                         16'(exp_fetch - exp_cons));
            end
            @(posedge clk);
            @(negedge clk);
        end
        n_chk++;
        if (n_cons < 300) begin
            n_fail++;
            $display("FAIL rnd.throughput: got %0d words consumed, expected at least 300", n_cons);
        end

        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
